seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  request valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: op  input  4  operation code, sampled on accept.
REQ-007 Port: a, b  input  WIDTH each  operands, sampled on accept.
REQ-008 Port: out_valid  output  1  result valid.
REQ-009 Port: out_ready  input  1  consumer accepts result.
REQ-010 Port: out  output  WIDTH  result.
REQ-011 Port: flags  output  4  {illegal, overflow, carry, zero}, qualified by out_valid.

Function
REQ-012 Op codes SHALL be: 0 add, 1 sub, 2 mul (low WIDTH bits), 3 divu quotient, 4 remu, 8 and, 9 or, 10 xor, 11 xnor, 12 shl, 13 shr (logical), 14 sra; all other codes SHALL be illegal.
REQ-013 Accept SHALL occur on a cycle with in_valid && in_ready; in_ready SHALL be high only in state IDLE.
REQ-014 FSM states: IDLE, BUSY, DONE; IDLE->DONE on accept of a single-cycle op; IDLE->BUSY on accept of ops 2-4; BUSY->DONE when iteration count reaches WIDTH; DONE->IDLE on out_ready.
REQ-015 Single-cycle ops SHALL produce out_valid on the cycle after accept (latency 1).
REQ-016 Ops 2-4 SHALL iterate one bit per cycle (shift-add multiply, restoring divide); out_valid SHALL rise exactly WIDTH+1 cycles after accept.
REQ-017 out_valid SHALL equal (state == DONE); out and flags SHALL hold stable while out_valid && !out_ready.
REQ-018 Inputs a, b, op SHALL be ignored when no accept occurs, including while BUSY or DONE.
REQ-019 Shift amount SHALL be b[log2(WIDTH)-1:0]; upper bits of b ignored; shift by 0 returns a.
REQ-020 carry: add = carry-out of bit WIDTH-1; sub = borrow (1 when a < b unsigned); mul = 1 if any discarded high product bit is nonzero; 0 for other ops.
REQ-021 overflow: signed two's-complement overflow for add/sub; 0 for other ops.
REQ-022 zero SHALL be 1 when out == 0, for every op including illegal.
REQ-023 Divide by zero: quotient SHALL be all ones, remainder SHALL be a, overflow = 1, completion latency unchanged.
REQ-024 Illegal op: single-cycle latency, out = 0, illegal = 1, zero = 1, other flags 0.

Reset
REQ-025 On rst_n low, state SHALL go to IDLE immediately, asynchronously, regardless of current state.
REQ-026 Reset values: in_ready = 1 after reset release, out_valid = 0, out = 0, flags = 0, iteration counter = 0.
REQ-027 Reset asserted during BUSY or DONE SHALL discard the operation; no out_valid SHALL follow for it.

Configuration
REQ-028 Macro SEQ_ALU_MULDIV_EN: when defined, ops 2-4 SHALL behave per REQ-016/023; BUSY state and iteration datapath present.
REQ-029 Without SEQ_ALU_MULDIV_EN, ops 2-4 SHALL be treated as illegal per REQ-024 and the BUSY state SHALL never be entered.

Verification
REQ-030 WIDTH=32, add a=0xFFFFFFFF, b=1 -> out=0 one cycle after accept, flags carry=1, zero=1, overflow=0.
REQ-031 WIDTH=32, sub a=0x80000000, b=1 -> out=0x7FFFFFFF, overflow=1, carry=0.
REQ-032 MULDIV_EN, mul a=0x10000, b=0x10000 -> out=0, carry=1, zero=1, out_valid exactly 33 cycles after accept.
REQ-033 MULDIV_EN, divu a=100, b=0 -> out=0xFFFFFFFF, overflow=1; remu a=100, b=7 -> out=2.
REQ-034 sra a=0x80000000, b=0x21 -> out=0xC0000000; hold out_ready=0 for 5 cycles -> out stable, in_ready=0 throughout.
REQ-035 Accept divu, assert rst_n=0 on cycle 10 -> out_valid stays 0, in_ready=1 after release; op=5 -> out=0, illegal=1.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU with a valid/ready request and result handshake.
// Optional iterative mul/divu/remu datapath, enabled by defining SEQ_ALU_MULDIV_EN.
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = SW + 1;

`ifdef SEQ_ALU_MULDIV_EN
    localparam bit MulDivEn = 1'b1;
`else
    localparam bit MulDivEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e state_q, state_d;

    logic             accept;
    logic             is_muldiv;
    logic             start_iter;
    logic             iter_done;
    logic [WIDTH-1:0] res_md;
    logic [3:0]       flg_md;
    logic [WIDTH-1:0] out_q;
    logic [3:0]       flags_q;

    assign accept     = in_valid && in_ready;
    assign is_muldiv  = (op == 4'd2) || (op == 4'd3) || (op == 4'd4);
    assign start_iter = accept && MulDivEn && is_muldiv;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = start_iter ? StBusy : StDone;
                end
            end
            StBusy: begin
                if (iter_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH:0]   add_r;
    logic [WIDTH:0]   sub_r;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] res_sc;
    logic             ill_sc;
    logic             ov_sc;
    logic             cy_sc;
    logic [3:0]       flg_sc;

    assign add_r = {1'b0, a} + {1'b0, b};
    assign sub_r = {1'b0, a} - {1'b0, b};
    assign shamt = b[SW-1:0];

    always_comb begin
        res_sc = '0;
        ill_sc = 1'b0;
        ov_sc  = 1'b0;
        cy_sc  = 1'b0;
        case (op)
            4'd0: begin
                res_sc = add_r[WIDTH-1:0];
                cy_sc  = add_r[WIDTH];
                ov_sc  = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: begin
                res_sc = sub_r[WIDTH-1:0];
                cy_sc  = sub_r[WIDTH];
                ov_sc  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
            end
            4'd8:  res_sc = a & b;
            4'd9:  res_sc = a | b;
            4'd10: res_sc = a ^ b;
            4'd11: res_sc = ~(a ^ b);
            4'd12: res_sc = a << shamt;
            4'd13: res_sc = a >> shamt;
            4'd14: res_sc = $unsigned($signed(a) >>> shamt);
            // Mul/div codes land here too; they only reach this path when the
            // iterative datapath is compiled out, and are then illegal.
            default: ill_sc = 1'b1;
        endcase
        flg_sc = {ill_sc, ov_sc, cy_sc, (res_sc == '0)};
    end

    // ---------------- iterative mul/div datapath ----------------
`ifdef SEQ_ALU_MULDIV_EN
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;

    // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign iter_done = (cnt_q == CW'(WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start_iter) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            acc_q <= (op == 4'd2) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
            cnt_q <= '0;
        end else if (state_q == StBusy && !iter_done) begin
            acc_q <= (op_q == 4'd2) ? mul_next : div_next;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Divide by zero falls out of the restoring loop as all-ones quotient, remainder a.
    always_comb begin
        res_md = acc_q[WIDTH-1:0];
        flg_md = '0;
        if (op_q == 4'd2) begin
            flg_md[1] = |acc_q[2*WIDTH-1:WIDTH];
        end else begin
            if (op_q == 4'd4) begin
                res_md = acc_q[2*WIDTH-1:WIDTH];
            end
            flg_md[2] = (b_q == '0);
        end
        flg_md[0] = (res_md == '0);
    end
`else
    assign iter_done = 1'b0;
    assign res_md    = '0;
    assign flg_md    = '0;
`endif

    // ---------------- result registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            flags_q <= '0;
        end else if (accept && !start_iter) begin
            out_q   <= res_sc;
            flags_q <= flg_sc;
        end else if (state_q == StBusy && iter_done) begin
            out_q   <= res_md;
            flags_q <= flg_md;
        end
    end

    assign out   = out_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes expected results, a negedge monitor
// checks latency, result, flags and hold behaviour whenever out_valid is high.
module tb_seq_alu;

`ifdef SEQ_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic [3:0]  flags;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc = 0;
    int   acc_cyc = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency on rise of out_valid, contents every valid cycle, pop on handshake.
    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_cyc = ncyc;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got out %h with empty scoreboard", out);
                end else begin
                    if (!prev_valid) check({sb[0].name, "_lat"}, ncyc - acc_cyc, sb[0].lat);
                    check({sb[0].name, "_out"}, out, sb[0].res);
                    check({sb[0].name, "_flags"}, {28'd0, flags}, {28'd0, sb[0].flg});
                    check({sb[0].name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic issue(input string name, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eo, input logic [3:0] ef,
                         input int lat);
        exp_t e;
        int   n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: in_ready low for %0d cycles, required high", name, n);
            in_valid = 1'b0;
            return;
        end
        e.res = eo;
        e.flg = ef;
        e.lat = lat;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Garbage operands while the request is in flight must be ignored.
        in_valid = 1'b0;
        op = 4'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out", out, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        issue("add_wrap",  4'd0,  32'hFFFF_FFFF, 32'd1,        32'd0,         4'b0011, 1);
        issue("sub_ovf",   4'd1,  32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 4'b0100, 1);
        issue("add_ovf",   4'd0,  32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 4'b0100, 1);
        issue("sub_brw",   4'd1,  32'd1,         32'd2,        32'hFFFF_FFFF, 4'b0010, 1);
        issue("and",       4'd8,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000, 1);
        issue("or",        4'd9,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b0000, 1);
        issue("xor",       4'd10, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 4'b0000, 1);
        issue("xor_zero",  4'd10, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd0,         4'b0001, 1);
        issue("xnor",      4'd11, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 4'b0000, 1);
        issue("shl_4",     4'd12, 32'd1,         32'h0000_0024, 32'h0000_0010, 4'b0000, 1);
        issue("shl_0",     4'd12, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 4'b0000, 1);
        issue("shr_31",    4'd13, 32'h8000_0000, 32'd31,       32'd1,         4'b0000, 1);
        issue("ill_15",    4'd15, 32'd1,         32'd2,        32'd0,         4'b1001, 1);
        drain("alu");

        // Hold the result for several cycles; the monitor checks it every cycle.
        out_ready = 1'b0;
        issue("sra_hold",  4'd14, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 4'b0000, 1);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain("sra");

        issue("mul_ovf",   4'd2, 32'h0001_0000, 32'h0001_0000, 32'd0, MD ? 4'b0011 : 4'b1001,
              MD ? 33 : 1);
        issue("mul_3x5",   4'd2, 32'd3, 32'd5, MD ? 32'd15 : 32'd0, MD ? 4'b0000 : 4'b1001,
              MD ? 33 : 1);
        issue("mul_m1",    4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD ? 32'd1 : 32'd0,
              MD ? 4'b0010 : 4'b1001, MD ? 33 : 1);
        issue("divu_z",    4'd3, 32'd100, 32'd0, MD ? 32'hFFFF_FFFF : 32'd0,
              MD ? 4'b0100 : 4'b1001, MD ? 33 : 1);
        issue("divu_7",    4'd3, 32'd100, 32'd7, MD ? 32'd14 : 32'd0, MD ? 4'b0000 : 4'b1001,
              MD ? 33 : 1);
        issue("remu_7",    4'd4, 32'd100, 32'd7, MD ? 32'd2 : 32'd0, MD ? 4'b0000 : 4'b1001,
              MD ? 33 : 1);
        issue("remu_z",    4'd4, 32'd5, 32'd0, MD ? 32'd5 : 32'd0, MD ? 4'b0100 : 4'b1001,
              MD ? 33 : 1);
        drain("muldiv");

        // Reset mid-operation discards it; no result may follow.
        out_ready = 1'b0;
        issue("divu_rst",  4'd3, 32'd100, 32'd7, MD ? 32'd14 : 32'd0, MD ? 4'b0000 : 4'b1001,
              MD ? 33 : 1);
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        check("post_rst_out", out, 32'd0);
        check("post_rst_flags", {28'd0, flags}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i % 10 == 0) begin
                check("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
                check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
            end
        end

        issue("ill_5",     4'd5, 32'd1, 32'd2, 32'd0, 4'b1001, 1);
        issue("add_after", 4'd0, 32'd20, 32'd22, 32'd42, 4'b0000, 1);
        drain("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
